// File: rtl/dac_seq_ctrl.sv
// Multi-channel DAC sample sequencer: FIFO of channel-tagged codes released one per tick.
// Optional slew limiting toward each channel's target is enabled by defining DAC_SLEW_LIMIT_EN.
//
// state    | meaning
// ST_IDLE  | tick counter frozen, FIFO still accepts pushes, outputs held
// ST_RUN   | counter counts down from period; each zero cycle is a tick
module dac_seq_ctrl #(
  parameter int WIDTH = 10,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16,
  parameter logic [WIDTH-1:0] RESET_CODE = '0,
  parameter int MAX_STEP = 4,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [DIV_W-1:0]            period,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic [CH_W-1:0]             s_chan,
  output logic [CHANNELS*WIDTH-1:0]   dac_out,
  output logic [CHANNELS-1:0]         dac_upd,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        underrun,
  input  logic                        clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("dac_seq_ctrl: CHANNELS must be 1..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dac_seq_ctrl: DEPTH must be a power of two >= 2");
  end
  if (MAX_STEP < 1) begin : g_bad_step
    $error("dac_seq_ctrl: MAX_STEP must be >= 1");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [CH_W+WIDTH-1:0] mem_q [DEPTH];
  logic [CH_W+WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                underrun_q, underrun_d;
  logic [WIDTH-1:0]    tgt_q [CHANNELS];
  logic [WIDTH-1:0]    tgt_d [CHANNELS];
  logic [WIDTH-1:0]    out_q [CHANNELS];
  logic [WIDTH-1:0]    out_d [CHANNELS];
  logic [CHANNELS-1:0] upd_q, upd_d;

  logic             tick, push, pop, full, empty;
  logic [CH_W-1:0]  head_chan;
  logic [WIDTH-1:0] head_data;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(MAX_STEP);

  // Difference is taken one bit wider than the code so it never wraps; the
  // final step lands exactly on the target.
  function automatic logic [WIDTH-1:0] slew_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] diff;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    if (diff > STEP_S)
      return cur + WIDTH'(MAX_STEP);
    else if (diff < -STEP_S)
      return cur - WIDTH'(MAX_STEP);
    else
      return tgt;
  endfunction
`endif

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = tick && !empty;
  assign {head_chan, head_data} = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = period;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = period;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {s_chan, s_data};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A tick on an empty FIFO beats a same-cycle clear.
    if (tick && empty)
      underrun_d = 1'b1;
    else if (clr_underrun)
      underrun_d = 1'b0;
    else
      underrun_d = underrun_q;
  end

  always_comb begin
    upd_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      tgt_d[k] = tgt_q[k];
      out_d[k] = out_q[k];
      // Entries tagged with a channel >= CHANNELS match nothing and are dropped.
      if (pop && head_chan == CH_W'(k)) tgt_d[k] = head_data;
      if (tick) begin
`ifdef DAC_SLEW_LIMIT_EN
        out_d[k] = slew_step(out_q[k], tgt_d[k]);
`else
        out_d[k] = tgt_d[k];
`endif
        upd_d[k] = (out_d[k] != out_q[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      upd_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        tgt_q[k] <= RESET_CODE;
        out_q[k] <= RESET_CODE;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      upd_q      <= upd_d;
      for (int k = 0; k < CHANNELS; k++) begin
        tgt_q[k] <= tgt_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    dac_out = '0;
    for (int k = 0; k < CHANNELS; k++) dac_out[k*WIDTH +: WIDTH] = out_q[k];
  end

  assign dac_upd  = upd_q;
  assign level    = level_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Self-checking bench for dac_seq_ctrl: vector table, hand sequences and an update scoreboard.
// Build with DAC_SLEW_LIMIT_EN defined to exercise the slew-limited variant.
module tb_dac_seq_ctrl;

  localparam int W = 10;
  localparam int CH = 2;
  localparam int D = 8;
  localparam int DW = 16;
  localparam logic [W-1:0] RC = 10'd512;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [DW-1:0]  period;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           s_chan;
  logic [CH*W-1:0] dac_out;
  logic [CH-1:0]  dac_upd;
  logic [3:0]     level;
  logic           underrun;
  logic           clr_underrun;

  always #5 clk = ~clk;

  dac_seq_ctrl #(
    .WIDTH(W), .CHANNELS(CH), .DEPTH(D), .DIV_W(DW), .RESET_CODE(RC), .MAX_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .period(period),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .dac_out(dac_out), .dac_upd(dac_upd), .level(level),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         ch;
    logic [W-1:0] d;
  } sb_t;

  sb_t          exp_q[$];
  logic [W-1:0] shadow [CH];

  typedef struct {
    logic         en;
    logic [DW-1:0] per;
    logic         sv;
    logic         ch;
    logic [W-1:0] d;
    logic         clr;
    int           lvl;
    int           rdy;
    int           und;
    int           upd;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic e, int p, logic sv, logic ch, int d, logic c,
                              int lvl, int rdy, int und, int upd);
    vec_t v;
    v.en = e; v.per = DW'(p); v.sv = sv; v.ch = ch; v.d = W'(d); v.clr = c;
    v.lvl = lvl; v.rdy = rdy; v.und = und; v.upd = upd;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // accept: the bench's own knowledge of whether the FIFO has room this cycle.
  task automatic drive(logic e, int p, logic sv, logic ch, int d, logic c, bit accept);
    en = e; period = DW'(p); s_valid = sv; s_chan = ch; s_data = W'(d); clr_underrun = c;
    if (sv && accept && W'(d) != shadow[ch]) begin
      exp_q.push_back({ch, W'(d)});
      shadow[ch] = W'(d);
    end
  endtask

`ifndef DAC_SLEW_LIMIT_EN
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < CH; k++) begin
        if (dac_upd[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_upd: ch%0d got %0d, expected no update", k, dac_out[k*W +: W]);
          end else begin
            sb_t e;
            e = exp_q.pop_front();
            chk("sb_chan", k, int'(e.ch));
            chk("sb_data", int'(dac_out[k*W +: W]), int'(e.d));
          end
        end
      end
    end
  end
`endif

  initial begin
    int n;
    reset = 1'b1; en = 1'b0; period = '0; s_valid = 1'b0; s_chan = 1'b0;
    s_data = '0; clr_underrun = 1'b0;
    shadow[0] = RC; shadow[1] = RC;
    repeat (3) step();

    chk("rst_dac_out", int'(dac_out), int'({RC, RC}));
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(s_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_upd", int'(dac_upd), 0);
    reset = 1'b0;

`ifdef DAC_SLEW_LIMIT_EN
    begin
      int exp_v [4] = '{516, 520, 522, 522};
      int exp_u [4] = '{1, 1, 1, 0};
      drive(1'b0, 0, 1'b1, 1'b0, 522, 1'b0, 1'b0);
      step();
      chk("slew_level", int'(level), 1);
      drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
        step();
        chk($sformatf("slew_ch0_t%0d", i), int'(dac_out[W-1:0]), exp_v[i]);
        chk($sformatf("slew_upd_t%0d", i), int'(dac_upd), exp_u[i]);
        chk($sformatf("slew_ch1_t%0d", i), int'(dac_out[2*W-1:W]), int'(RC));
      end
      drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      step();
    end
`else
    //           en per sv ch  d   clr  lvl rdy und upd
    tbl[0]  = mk(1, 0, 1, 0, 100, 0,   1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 200, 0,   2, 1, 0, 0);
    tbl[0].en = 1'b0;
    tbl[2]  = mk(1, 3, 0, 0, 0,   0,   2, 1, 0, 0);
    tbl[3]  = mk(1, 3, 0, 0, 0,   0,   2, 1, 0, 0);
    tbl[4]  = mk(1, 3, 0, 0, 0,   0,   2, 1, 0, 0);
    tbl[5]  = mk(1, 3, 0, 0, 0,   0,   2, 1, 0, 0);
    tbl[6]  = mk(1, 3, 0, 0, 0,   0,   1, 1, 0, 1);
    tbl[7]  = mk(1, 3, 0, 0, 0,   0,   1, 1, 0, 0);
    tbl[8]  = mk(1, 3, 0, 0, 0,   0,   1, 1, 0, 0);
    tbl[9]  = mk(1, 3, 0, 0, 0,   0,   1, 1, 0, 0);
    tbl[10] = mk(1, 3, 0, 0, 0,   0,   0, 1, 0, 2);
    tbl[11] = mk(1, 3, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[12] = mk(1, 3, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[13] = mk(1, 3, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[14] = mk(1, 3, 0, 0, 0,   0,   0, 1, 1, 0);
    tbl[15] = mk(1, 3, 0, 0, 0,   1,   0, 1, 0, 0);
    tbl[16] = mk(0, 3, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[19] = mk(1, 1, 0, 0, 0,   1,   0, 1, 1, 0);
    tbl[20] = mk(1, 1, 0, 0, 0,   1,   0, 1, 0, 0);
    tbl[21] = mk(1, 1, 0, 0, 0,   0,   0, 1, 1, 0);
    tbl[22] = mk(0, 1, 0, 0, 0,   1,   0, 1, 0, 0);
    tbl[23] = mk(0, 0, 1, 0, 100, 0,   1, 1, 0, 0);
    tbl[24] = mk(1, 0, 0, 0, 0,   0,   1, 1, 0, 0);
    tbl[25] = mk(1, 0, 0, 0, 0,   0,   0, 1, 0, 0);
    tbl[26] = mk(0, 0, 0, 0, 0,   0,   0, 1, 0, 0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].en, int'(tbl[i].per), tbl[i].sv, tbl[i].ch, int'(tbl[i].d), tbl[i].clr, 1'b1);
      step();
      chk($sformatf("v%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("v%0d_ready", i), int'(s_ready), tbl[i].rdy);
      chk($sformatf("v%0d_underrun", i), int'(underrun), tbl[i].und);
      chk($sformatf("v%0d_upd", i), int'(dac_upd), tbl[i].upd);
    end

    // Fill to full while idle; pointers start mid-array so the drain wraps.
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 0, 1'b1, (i % 2) != 0, 300 + i * 7, 1'b0, 1'b1);
      step();
      chk($sformatf("fill%0d_level", i), int'(level), i + 1);
    end
    chk("full_ready", int'(s_ready), 0);
    drive(1'b0, 0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    step();
    chk("ninth_level", int'(level), D);
    chk("ninth_ready", int'(s_ready), 0);
    drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step();
    chk("run_entry_level", int'(level), D);
    drive(1'b1, 0, 1'b1, 1'b0, 999, 1'b0, 1'b0);
    step();
    chk("full_pop_push_rejected", int'(level), D - 1);
    chk("after_pop_ready", int'(s_ready), 1);
    drive(1'b1, 0, 1'b1, 1'b1, 777, 1'b0, 1'b1);
    step();
    chk("push_pop_same_level", int'(level), D - 1);
    drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    n = 0;
    while (level != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_cycles", n, D - 1);
    chk("drain_level", int'(level), 0);
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step();
    chk("drain_no_underrun", int'(underrun), 0);
    chk("sb_drained", exp_q.size(), 0);

    // Reset in the middle of a run with five words queued.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 1'b1, (i % 2) != 0, 600 + i, 1'b0, 1'b1);
      step();
    end
    chk("pre_reset_level", int'(level), 5);
    drive(1'b1, 9, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    shadow[0] = RC; shadow[1] = RC;
    drive(1'b1, 3, 1'b1, 1'b0, 50, 1'b0, 1'b0);
    step();
    chk("midrst_level", int'(level), 0);
    chk("midrst_ready", int'(s_ready), 1);
    chk("midrst_dac_out", int'(dac_out), int'({RC, RC}));
    chk("midrst_upd", int'(dac_upd), 0);
    chk("midrst_underrun", int'(underrun), 0);
    reset = 1'b0;
    drive(1'b1, 3, 1'b1, 1'b0, 40, 1'b0, 1'b1);
    step();
    chk("postrst_r1_level", int'(level), 1);
    chk("postrst_r1_underrun", int'(underrun), 0);
    drive(1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step();
    chk("postrst_r4_level", int'(level), 1);
    step();
    chk("postrst_r5_level", int'(level), 0);
    drive(1'b0, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step();
    chk("postrst_ch0", int'(dac_out[W-1:0]), 40);
    chk("postrst_sb_drained", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_seq_ctrl.md
# dac_seq_ctrl

Parametrised, multi-channel sample sequencer between the alphacore store path and the avsddac digital inputs. It buffers channel-tagged sample words in a FIFO and releases one word per programmable update period onto per-channel hold registers driving the DAC codes. It is the generalised successor of the single-channel, direct-write DAC path: width, depth and channel count are configurable, with rate control and underrun reporting. An optional slew limiter is also available.

## Interface
- WIDTH, 10: DAC code width, bits.
- CHANNELS, 2: number of DAC channels, 1..8.
- DEPTH, 8: FIFO entries, power of two, at least 2.
- DIV_W, 16: width of the period counter.
- RESET_CODE, 0: value loaded into every channel output on reset.
- MAX_STEP, 4: maximum code change per tick. Used only with DAC_SLEW_LIMIT_EN.
- CH_W: derived; max(1, clog2(CHANNELS)).
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- en  in  1  sequencer run enable.
- period  in  DIV_W  update interval minus 1, in clk cycles.
- s_valid  in  1  sample word offered.
- s_ready  out  1  FIFO can accept a word; equals !full.
- s_data  in  WIDTH  sample code.
- s_chan  in  CH_W  target channel. Values ≥ CHANNELS are accepted and discarded at pop.
- dac_out  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- dac_upd  out  CHANNELS  one-cycle strobe per channel whose dac_out changed.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- underrun  out  1  sticky; set when a tick finds the FIFO empty.
- clr_underrun  in  1  clears underrun.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE to RUN when en=1. The tick counter is loaded with period on entry.
  - RUN to IDLE when en=0, on the next edge. The counter freezes, and FIFO contents and channel outputs are held.
- Tick counter runs in RUN only:
  - It counts down to 0. The cycle at 0 is a tick, and the counter reloads with period in that cycle.
  - period=0 gives a tick every cycle.
  - A change to period takes effect at the next reload.
- Push: s_valid && s_ready writes {s_chan, s_data}. The FIFO accepts pushes in both states.
- Pop: on a tick with level>0, the head entry is popped.
  - The entry's channel target register is loaded with its data.
  - An entry with an invalid channel is popped and dropped, with no update.
- Underrun: on a tick with level=0, underrun is set and all outputs hold.
  - If clr_underrun and an underrun event occur in the same cycle, the set wins.
- Push and pop in the same cycle: both occur and level is unchanged.
- When full, s_ready=0 even if a pop occurs in that cycle. s_ready is not combinationally dependent on the pop.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. level distinguishes full from empty.
- Reset:
  - FIFO is flushed: level=0, s_ready=1.
  - All dac_out and target registers take RESET_CODE.
  - dac_upd=0, underrun=0, FSM goes to IDLE.
  - Reset overrides every other input in the same cycle, including mid-run.

## Timing
- Push at edge N: level increments at N+1. The word is poppable by a tick at N+1 or later.
- Tick at cycle T (without the macro): dac_out[chan] = data and dac_upd[chan]=1 at T+1, for exactly one cycle.
- If the popped data equals the current output, dac_out is unchanged and dac_upd stays 0.
- With period=P in steady RUN, consecutive ticks are P+1 cycles apart.
- The first tick after entering RUN occurs P+1 cycles after en is sampled high.
- underrun rises at T+1 after an empty tick.

## Configuration
- DAC_SLEW_LIMIT_EN defined:
  - On every tick, each channel moves dac_out toward its target by min(|target−dac_out|, MAX_STEP).
  - dac_upd strobes at T+1 for each channel that moved.
  - The difference is computed in WIDTH+1 bits and the result is clamped at target, with no wrap.
  - Popping into the target register happens on the same tick, and that channel steps from its old value in the same update.
- DAC_SLEW_LIMIT_EN undefined: dac_out is loaded with the target directly at T+1. MAX_STEP is ignored.

## Test plan
- Reset with RESET_CODE=512, CHANNELS=2 -> both dac_out=512, level=0, s_ready=1, underrun=0, dac_upd=0.
- period=3, en=1, push (ch0,100),(ch1,200) -> ticks 4 cycles apart. ch0=100 with dac_upd=01 on the first tick+1; ch1=200 with dac_upd=10 four cycles later.
- Push 8 words with en=0, DEPTH=8 -> s_ready=0 and level=8. A 9th s_valid is not accepted. Then en=1, period=0 -> one pop per cycle with wrap-around, in order, and level back to 0.
- Empty FIFO, en=1, period=1 -> underrun=1 after the first tick, outputs unchanged. clr_underrun clears it. A simultaneous empty tick keeps it set.
- Assert reset mid-run with level=5 -> next cycle level=0, outputs=RESET_CODE, FSM in IDLE.
- With DAC_SLEW_LIMIT_EN, MAX_STEP=4, ch0 0→10 -> ch0 values 4, 8, 10 on successive ticks, then no further dac_upd.
